uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 22 ++
 rtl/uart_frame_parser_if.sv | 36 +++
 rtl/uart_frame_buf.sv | 31 +++
 rtl/uart_frame_parser.sv | 155 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame parser.
// Holds the parser state encoding, the error codes reported on err_code
// and the default frame start marker.
package uart_frame_pkg;

  // State encoding kept as plain constants so legacy tools and probes can
  // compare against fixed bit patterns.
  typedef logic [2:0] state_t;

  localparam state_t S_HUNT    = 3'd0;
  localparam state_t S_CMD     = 3'd1;
  localparam state_t S_LEN     = 3'd2;
  localparam state_t S_PAYLOAD = 3'd3;
  localparam state_t S_CHK     = 3'd4;

  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Bus bundle between the UART byte receiver / sensor control path and the
// frame parser.
//   rx_data/rx_done         : received byte and its one-cycle strobe
//   rd_addr/rd_data         : payload buffer read port
//   frame_valid/cmd/len     : good-frame pulse and last good header
//   frame_err/err_code      : abort pulse and held error code
//   busy                    : parser is inside a frame
// master = byte source / payload reader, slave = parser.
interface uart_frame_parser_if #(
  parameter int MAX_LEN = 16
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;

  logic [7:0]    rx_data;
  logic          rx_done;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_valid;
  logic [7:0]    frame_cmd;
  logic [LW-1:0] frame_len;
  logic          frame_err;
  logic [1:0]    err_code;
  logic          busy;

  modport master (
    output rx_data, rx_done, rd_addr,
    input  rd_data, frame_valid, frame_cmd, frame_len, frame_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_done, rd_addr,
    output rd_data, frame_valid, frame_cmd, frame_len, frame_err, err_code, busy
  );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: MAX_LEN x 8 register file, one synchronous write port and
// one combinational read port. Contents are intentionally not reset.
// Ports:
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
module uart_frame_buf #(
  parameter int MAX_LEN = 16
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(MAX_LEN)-1:0] i_waddr,
  input  logic [7:0]                 i_wdata,
  input  logic [$clog2(MAX_LEN)-1:0] i_raddr,
  output logic [7:0]                 o_rdata
);

  logic [7:0] r_mem [MAX_LEN];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser: assembles SYNC, CMD, LEN, PAYLOAD[0..LEN-1], CHK frames
// from the byte receiver, where CHK is the XOR of CMD, LEN and all payload
// bytes. A good frame produces a one-cycle frame_valid and updates
// frame_cmd/frame_len; a malformed frame produces a one-cycle frame_err with
// a held err_code (1 checksum, 2 length, 3 timeout).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_frame_parser_if.slave (byte input, payload read port,
//              frame status outputs)
// Optional build macro UART_FRAME_TIMEOUT_EN adds an inter-byte timeout
// that aborts a partial frame after TIMEOUT_CLKS idle cycles.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 52080
) (
  input  logic                clk,
  input  logic                rst,
  uart_frame_parser_if.slave  bus
);

  localparam int         AW        = $clog2(MAX_LEN);
  localparam int         LW        = AW + 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t        r_state;
  logic [7:0]    r_chk;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_cmd_stg;
  logic [LW-1:0] r_len_stg;
  logic          r_frame_valid;
  logic [7:0]    r_frame_cmd;
  logic [LW-1:0] r_frame_len;
  logic          r_frame_err;
  logic [1:0]    r_err_code;

  logic          w_we;
  logic          w_last;
  logic          w_tmo_hit;

  // Last payload byte: the index already points at LEN-1.
  assign w_last = ({1'b0, r_idx} == (r_len_stg - LW'(1)));
  assign w_we   = bus.rx_done && (r_state == S_PAYLOAD);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  logic [TW-1:0] r_tmo_cnt;

  // A byte arriving on the terminal count wins over the timeout.
  assign w_tmo_hit = (r_state != S_HUNT) && !bus.rx_done &&
                     (r_tmo_cnt == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_HUNT) || bus.rx_done || w_tmo_hit) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_HUNT;
      r_chk         <= '0;
      r_idx         <= '0;
      r_cmd_stg     <= '0;
      r_len_stg     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_cmd   <= '0;
      r_frame_len   <= '0;
      r_frame_err   <= 1'b0;
      r_err_code    <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (bus.rx_done) begin
        case (r_state)
          S_HUNT: begin
            if (bus.rx_data == SYNC_BYTE) begin
              r_state <= S_CMD;
            end
          end
          S_CMD: begin
            r_cmd_stg <= bus.rx_data;
            r_chk     <= bus.rx_data;
            r_state   <= S_LEN;
          end
          S_LEN: begin
            if (bus.rx_data > MAX_LEN_B) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_LEN;
              r_state     <= S_HUNT;
            end else begin
              r_len_stg <= bus.rx_data[LW-1:0];
              r_chk     <= r_chk ^ bus.rx_data;
              r_idx     <= '0;
              r_state   <= (bus.rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            r_chk <= r_chk ^ bus.rx_data;
            if (w_last) begin
              r_state <= S_CHK;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
          S_CHK: begin
            if (bus.rx_data == r_chk) begin
              r_frame_valid <= 1'b1;
              r_frame_cmd   <= r_cmd_stg;
              r_frame_len   <= r_len_stg;
            end else begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_CHK;
            end
            r_state <= S_HUNT;
          end
          default: r_state <= S_HUNT;
        endcase
      end else if (w_tmo_hit) begin
        r_frame_err <= 1'b1;
        r_err_code  <= ERR_TMO;
        r_state     <= S_HUNT;
      end
    end
  end

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (bus.rx_data),
    .i_raddr (bus.rd_addr),
    .o_rdata (bus.rd_data)
  );

  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_cmd   = r_frame_cmd;
  assign bus.frame_len   = r_frame_len;
  assign bus.frame_err   = r_frame_err;
  assign bus.err_code    = r_err_code;
  assign bus.busy        = (r_state != S_HUNT);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed testbench for uart_frame_parser. Bytes are driven on the falling
// edge and outputs are sampled on the falling edge after each strobe.
module tb_uart_frame_parser;

  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #10 clk = ~clk;

  uart_frame_parser_if #(.MAX_LEN(16)) bus ();

  uart_frame_parser #(
    .SYNC_BYTE    (8'hAA),
    .MAX_LEN      (16),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Called at a falling edge; strobes one byte across the next rising edge
  // and returns on the following falling edge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic test_reset();
    n_vec++;
    if (bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pulses: valid=%b err=%b busy=%b, want 0 0 0",
               bus.frame_valid, bus.frame_err, bus.busy);
    end
    n_vec++;
    if (bus.frame_cmd !== 8'h00 || bus.frame_len !== 5'd0 || bus.err_code !== 2'd0) begin
      n_err++;
      $display("FAIL reset_regs: cmd=%h len=%0d code=%0d, want 00 0 0",
               bus.frame_cmd, bus.frame_len, bus.err_code);
    end
  endtask

  task automatic test_good_frame();
    send_byte(8'hAA);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL good_busy_after_sync: got %b want 1", bus.busy);
    end
    send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    n_vec++;
    if (bus.frame_valid !== 1'b0) begin
      n_err++; $display("FAIL good_early_valid: got %b want 0", bus.frame_valid);
    end
    send_byte(8'h13);
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.frame_err !== 1'b0) begin
      n_err++; $display("FAIL good_valid: valid=%b err=%b want 1 0", bus.frame_valid, bus.frame_err);
    end
    n_vec++;
    if (bus.frame_cmd !== 8'h10 || bus.frame_len !== 5'd3) begin
      n_err++; $display("FAIL good_hdr: cmd=%h len=%0d want 10 3", bus.frame_cmd, bus.frame_len);
    end
    @(negedge clk);
    n_vec++;
    if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL good_pulse_end: valid=%b busy=%b want 0 0", bus.frame_valid, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr = 4'(i);
      #1;
      n_vec++;
      if (bus.rd_data !== 8'(i + 1)) begin
        n_err++; $display("FAIL good_payload[%0d]: got %h want %h", i, bus.rd_data, 8'(i + 1));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    send_byte(8'hAA); send_byte(8'h22); send_byte(8'h00); send_byte(8'h22);
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h22 || bus.frame_len !== 5'd0) begin
      n_err++; $display("FAIL zero_len: valid=%b cmd=%h len=%0d want 1 22 0",
                        bus.frame_valid, bus.frame_cmd, bus.frame_len);
    end
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr = 4'(i);
      #1;
      n_vec++;
      if (bus.rd_data !== 8'(i + 1)) begin
        n_err++; $display("FAIL zero_len_keep[%0d]: got %h want %h", i, bus.rd_data, 8'(i + 1));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_bad_chk();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h01); send_byte(8'h55); send_byte(8'h00);
    n_vec++;
    if (bus.frame_err !== 1'b1 || bus.err_code !== 2'd1 || bus.frame_valid !== 1'b0) begin
      n_err++; $display("FAIL bad_chk: err=%b code=%0d valid=%b want 1 1 0",
                        bus.frame_err, bus.err_code, bus.frame_valid);
    end
    n_vec++;
    if (bus.frame_cmd !== 8'h22) begin
      n_err++; $display("FAIL bad_chk_cmd_kept: got %h want 22", bus.frame_cmd);
    end
    @(negedge clk);
    n_vec++;
    if (bus.frame_err !== 1'b0 || bus.err_code !== 2'd1) begin
      n_err++; $display("FAIL bad_chk_pulse_end: err=%b code=%0d want 0 1", bus.frame_err, bus.err_code);
    end
    // 33 ^ 01 ^ 7E = 4C
    send_byte(8'hAA); send_byte(8'h33); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h4C);
    bus.rd_addr = 4'd0;
    #1;
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h33 || bus.frame_len !== 5'd1 ||
        bus.rd_data !== 8'h7E) begin
      n_err++; $display("FAIL bad_chk_recover: valid=%b cmd=%h len=%0d rd0=%h want 1 33 1 7e",
                        bus.frame_valid, bus.frame_cmd, bus.frame_len, bus.rd_data);
    end
    @(negedge clk);
  endtask

  task automatic test_len_err();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h11);
    n_vec++;
    if (bus.frame_err !== 1'b1 || bus.err_code !== 2'd2 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL len_err: err=%b code=%0d busy=%b want 1 2 0",
                        bus.frame_err, bus.err_code, bus.busy);
    end
    send_byte(8'h11);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.frame_err !== 1'b0 || bus.frame_valid !== 1'b0) begin
      n_err++; $display("FAIL len_err_hunt_ignore: busy=%b err=%b valid=%b want 0 0 0",
                        bus.busy, bus.frame_err, bus.frame_valid);
    end
    // LEN == MAX_LEN is legal; 16 payload bytes 0..15 XOR to 00, so CHK = 40^10 = 50
    send_byte(8'hAA); send_byte(8'h40); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h50);
    bus.rd_addr = 4'd15;
    #1;
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.frame_len !== 5'd16 || bus.rd_data !== 8'h0F) begin
      n_err++; $display("FAIL len_max: valid=%b len=%0d rd15=%h want 1 16 0f",
                        bus.frame_valid, bus.frame_len, bus.rd_data);
    end
    @(negedge clk);
  endtask

`ifdef UART_FRAME_TIMEOUT_EN
  task automatic test_timeout();
    int waited;
    bit seen;
    send_byte(8'hAA); send_byte(8'h10);
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 3 * TMO) begin
      @(negedge clk);
      waited++;
      if (bus.frame_err === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen || waited != TMO) begin
      n_err++; $display("FAIL timeout_fire: seen=%b after %0d cycles want 1 after %0d", seen, waited, TMO);
    end
    n_vec++;
    if (bus.err_code !== 2'd3 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL timeout_state: code=%0d busy=%b want 3 0", bus.err_code, bus.busy);
    end
    @(negedge clk);
    // Byte lands exactly on the terminal count: no timeout.
    send_byte(8'hAA); send_byte(8'h10);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h01);
    n_vec++;
    if (bus.frame_err !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL timeout_terminal_byte: err=%b busy=%b want 0 1", bus.frame_err, bus.busy);
    end
    // 10 ^ 01 ^ 05 = 14
    send_byte(8'h05); send_byte(8'h14);
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.frame_len !== 5'd1) begin
      n_err++; $display("FAIL timeout_terminal_frame: valid=%b len=%0d want 1 1",
                        bus.frame_valid, bus.frame_len);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_midframe();
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h05); send_byte(8'h01);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_busy: got %b want 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0 ||
        bus.frame_cmd !== 8'h00 || bus.frame_len !== 5'd0 || bus.err_code !== 2'd0) begin
      n_err++; $display("FAIL rst_mid_outputs: busy=%b v=%b e=%b cmd=%h len=%0d code=%0d want all 0",
                        bus.busy, bus.frame_valid, bus.frame_err, bus.frame_cmd,
                        bus.frame_len, bus.err_code);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_no_err: err=%b busy=%b want 0 0", bus.frame_err, bus.busy);
    end
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h13);
    bus.rd_addr = 4'd2;
    #1;
    n_vec++;
    if (bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h10 || bus.frame_len !== 5'd3 ||
        bus.rd_data !== 8'h03) begin
      n_err++; $display("FAIL rst_mid_recover: valid=%b cmd=%h len=%0d rd2=%h want 1 10 3 03",
                        bus.frame_valid, bus.frame_cmd, bus.frame_len, bus.rd_data);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_good_frame();
    test_zero_len();
    test_bad_chk();
    test_len_err();
`ifdef UART_FRAME_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
